// File: rtl/enc_pkg.sv
// Shared definitions for the ADPCM encoder input sequencer.
package enc_pkg;

  // PCM sample width.
  localparam int unsigned PcmW = 8;

  // Default WAIT-state abort limit, in cycles.
  localparam int unsigned DefTimeout = 64;

  // Sequencer state encoding.
  typedef logic [2:0] enc_state_t;

  localparam enc_state_t StIdle  = 3'd0;
  localparam enc_state_t StSetup = 3'd1;
  localparam enc_state_t StLoad  = 3'd2;
  localparam enc_state_t StStart = 3'd3;
  localparam enc_state_t StWait  = 3'd4;

endpackage

// File: rtl/enc_in_ctrl_if.sv
// PCM sample stream (valid/ready) between the sample source and the sequencer.
interface enc_in_ctrl_if;
  import enc_pkg::*;

  logic            s_valid;
  logic [PcmW-1:0] s_data;
  logic            s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/enc_in_fifo.sv
// DEPTH x PcmW sample FIFO with registered full/empty flags and a head view.
module enc_in_fifo
  import enc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [PcmW-1:0] data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [PcmW-1:0] head_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PcmW-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            full_q, full_d, empty_q, empty_d;
  logic            do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = mem_q[rptr_q];

  // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of 2.
  always_comb begin
    wptr_d = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = do_pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + (AW + 1)'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - (AW + 1)'(1);
    full_d  = (cnt_d == (AW + 1)'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // Storage array; contents need no reset because empty_q gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  // Pointer, count and flag state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: rtl/enc_in_ctrl.sv
// ADPCM encoder input sequencer: buffers PCM samples and, per sample, sets up
// the input register, strobes its load, starts the encoder and waits for done.
// Optional WAIT abort with sticky timeout_err is enabled by ENC_IN_TIMEOUT_EN.
module enc_in_ctrl
  import enc_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             clk,
  input  logic             reset,
  enc_in_ctrl_if.slave     s_if,
  output logic [PcmW-1:0]  reg_data,
  output logic             reg_load,
  output logic             enc_start,
  input  logic             enc_done,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  input  logic             err_clr,
  output logic             timeout_err
);
  logic            fifo_full, fifo_empty, push, pop;
  logic [PcmW-1:0] fifo_head;
  logic            live_q;
  enc_state_t      state_q, state_d;
  logic [PcmW-1:0] data_q, data_d;
  logic            load_q, load_d, start_q, start_d, busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            tmo_hit;

  // live_q keeps s_ready low while reset is asserted.
  assign s_if.s_ready = live_q & ~fifo_full;
  assign push         = s_if.s_valid & s_if.s_ready;

  enc_in_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .data_i  (s_if.s_data),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

`ifdef ENC_IN_TIMEOUT_EN
  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;

  assign tmo_hit     = (state_q == StWait) && !enc_done && (wait_q == WaitW'(TIMEOUT - 1));
  assign timeout_err = err_q;

  // WAIT cycle counter restarts on every WAIT entry; a new timeout beats err_clr.
  always_comb begin
    wait_d = (state_q == StWait) ? wait_q + WaitW'(1) : '0;
    err_d  = tmo_hit | (err_q & ~err_clr);
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
`else
  logic unused_cfg;

  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = err_clr | (TIMEOUT == 0);
`endif

  // Sequencer next-state; strobes are computed one state ahead so they come off flops.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    load_d  = 1'b0;
    start_d = 1'b0;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_head;
          state_d = StSetup;
        end
      end
      StSetup: begin
        load_d  = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        start_d = 1'b1;
        state_d = StStart;
      end
      // enc_done is not looked at here, even if it coincides with enc_start.
      StStart: state_d = StWait;
      StWait: begin
        if (enc_done) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StIdle;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q  <= 1'b0;
      state_q <= StIdle;
      data_q  <= '0;
      load_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      live_q  <= 1'b1;
      state_q <= state_d;
      data_q  <= data_d;
      load_q  <= load_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign reg_data   = data_q;
  assign reg_load   = load_q;
  assign enc_start  = start_q;
  assign busy       = busy_q;
  assign sample_cnt = cnt_q;

endmodule
